// File: rtl/ram_arbiter_if.sv
// Client-side bundle of the two-requester RAM arbiter: per-client request/grant
// handshake plus the shared read-data return.
interface ram_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic                  lock0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [WIDTH-1:0]      wdata0;
  logic                  gnt0;
  logic                  rvalid0;

  logic                  req1;
  logic                  we1;
  logic                  lock1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [WIDTH-1:0]      wdata1;
  logic                  gnt1;
  logic                  rvalid1;

  logic [WIDTH-1:0]      rdata;

  // Client side drives requests and consumes grants/read data.
  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );
endinterface

// File: rtl/ram_sp.sv
// Single-port synchronous block RAM: write on the clock edge when we is high,
// registered read with one cycle of latency.
module ram_sp #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);
  logic [WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end
endmodule

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick. When force_en is set, requester
// force_id wins any contention regardless of last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic force_en,
  input  logic force_id,
  output logic gnt0,
  output logic gnt1
);
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (force_en) begin
      // The owner keeps priority; the other side only gets idle owner cycles.
      if (!force_id) begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
      end else begin
        gnt1 = req1;
        gnt0 = req0 & ~req1;
      end
    end else if (req0 && req1) begin
      gnt0 = last;
      gnt1 = ~last;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port BRAM between two clients: round-robin arbitration with
// a bounded ownership lock for read-modify-write, and a 1-cycle rvalid pipeline.
module ram_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LOCK_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_dout
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

  state_t     state_reg, state_next;
  logic [3:0] lock_cnt_reg, lock_cnt_next;
  logic       last_reg, last_next;
  logic       rvalid0_reg, rvalid1_reg;
  logic       pick0, pick1;
  logic       gnt0, gnt1;
  logic       force_en, force_id;

  assign force_en = (state_reg != IDLE);
  assign force_id = (state_reg == OWN1);

  rr_pick2 u_pick (
    .req0     (bus.req0),
    .req1     (bus.req1),
    .last     (last_reg),
    .force_en (force_en),
    .force_id (force_id),
    .gnt0     (pick0),
    .gnt1     (pick1)
  );

  // Reset masks grants combinationally so no access reaches the RAM during rst.
  assign gnt0 = pick0 & ~rst;
  assign gnt1 = pick1 & ~rst;

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_reg & ~rst;
  assign bus.rvalid1 = rvalid1_reg & ~rst;
  assign bus.rdata   = ram_dout;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_we   = bus.we0;
      ram_addr = bus.addr0;
      ram_din  = bus.wdata0;
    end else if (gnt1) begin
      ram_we   = bus.we1;
      ram_addr = bus.addr1;
      ram_din  = bus.wdata1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    last_next     = last_reg;
    if (gnt0) begin
      last_next = 1'b0;
    end else if (gnt1) begin
      last_next = 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (gnt0 && bus.lock0) begin
          state_next    = OWN0;
          lock_cnt_next = 4'd1;
        end else if (gnt1 && bus.lock1) begin
          state_next    = OWN1;
          lock_cnt_next = 4'd1;
        end
      end
      OWN0: begin
        if (!bus.req0 || (gnt0 && !bus.lock0)) begin
          state_next    = IDLE;
          lock_cnt_next = 4'd0;
        end else if (gnt0) begin
          // Hitting the bound releases ownership; last=0 hands the next tie to 1.
          if (lock_cnt_reg >= LOCK_LIMIT - 4'd1) begin
            state_next    = IDLE;
            lock_cnt_next = 4'd0;
          end else begin
            lock_cnt_next = lock_cnt_reg + 4'd1;
          end
        end
      end
      OWN1: begin
        if (!bus.req1 || (gnt1 && !bus.lock1)) begin
          state_next    = IDLE;
          lock_cnt_next = 4'd0;
        end else if (gnt1) begin
          if (lock_cnt_reg >= LOCK_LIMIT - 4'd1) begin
            state_next    = IDLE;
            lock_cnt_next = 4'd0;
          end else begin
            lock_cnt_next = lock_cnt_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lock_cnt_reg <= 4'd0;
      last_reg     <= 1'b1;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      last_reg     <= last_next;
      rvalid0_reg  <= gnt0 & ~bus.we0;
      rvalid1_reg  <= gnt1 & ~bus.we1;
    end
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous BRAM (WIDTH x 2^ADDR_WIDTH, 1-cycle read latency, write on clk edge when we is high) between two requesters.
- At most one access is issued per cycle. Arbitration is round-robin, with an optional bounded lock for read-modify-write sequences.
- The block sits between the BRAM instance and two clients, for example a sieve writer and a scanner reader on the icestick design.

Parameters:
- WIDTH, 16, data width of the RAM and both clients.
- ADDR_WIDTH, 8, RAM address width.
- LOCK_MAX, 4, maximum consecutive grants one requester may hold while lock is asserted (range 1..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants an access this cycle.
- we0  in  1  1 = write, 0 = read (requester 0).
- lock0  in  1  request to keep ownership after this access (requester 0).
- addr0  in  ADDR_WIDTH  address (requester 0).
- wdata0  in  WIDTH  write data (requester 0).
- gnt0  out  1  access accepted this cycle (combinational).
- rvalid0  out  1  rdata holds requester 0's read result.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1: same as requester 0, for requester 1.
- rdata  out  WIDTH  read data, shared by both requesters (qualified by rvalidN).
- ram_addr  out  ADDR_WIDTH  to BRAM address.
- ram_din  out  WIDTH  to BRAM write data.
- ram_we  out  1  to BRAM write enable.
- ram_dout  in  WIDTH  from BRAM, valid the cycle after address is presented.

Behaviour:
- Handshake: an access completes in the cycle where reqN and gntN are both 1. The client holds weN/addrN/wdataN stable until granted. gntN is never 1 when reqN is 0. gnt0 and gnt1 are never both 1.
- Port mux:
  - When gntN is 1: ram_addr=addrN, ram_din=wdataN, ram_we=weN.
  - With no grant: ram_we=0, ram_addr=0, ram_din=0.
- Read latency: a granted read at cycle t gives rvalidN=1 at t+1 with rdata=ram_dout. rvalidN is a registered single-cycle pulse. Writes never raise rvalid.
- Back-to-back: a new grant is allowed every cycle. Read-after-write to the same address in consecutive cycles returns the new data.
- Round-robin:
  - Register last (1 bit) holds the requester granted most recently. Reset value is 1, so requester 0 wins the first tie.
  - If only one requester asserts req, it is granted.
  - If both assert req, the requester != last is granted, except while locked (see below).
- Lock FSM, states IDLE, OWN0, OWN1, plus lock_cnt (4 bits):
  - IDLE -> OWNn when gntn and lockn are 1; lock_cnt=1.
  - In OWNn: reqn has absolute priority; the other requester gets no grant while reqn=1.
    - Each grant with lockn=1 increments lock_cnt.
    - If lock_cnt==LOCK_MAX, go to IDLE and set last=n, so the other requester wins the next tie.
  - OWNn -> IDLE when reqn=0 (ownership dropped; the other requester may be granted in this same cycle), or when a grant occurs with lockn=0.
  - LOCK_MAX=1 means lock never gives more than one extra priority cycle.
- Simultaneous events:
  - Both requesters assert lock in a tie: only the granted one enters OWN.
  - A lock asserted by a non-granted requester is ignored.
- Reset: while rst=1, gnt0=gnt1=0, ram_we=0, ram_addr=0, ram_din=0. Registers take these values: rvalid0=rvalid1=0, last=1, state=IDLE, lock_cnt=0.
- Reset mid-operation: a read granted in the cycle before rst rises gives no rvalid. A write is never issued during rst.
- No combinational path from ram_dout to any gnt.

Decomposition:
- No shared package. FSM state encodings are localparams inside ram_arbiter. WIDTH/ADDR_WIDTH defaults match the existing ram block so the two instantiate together.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin pick taking req0, req1, last, force_en, force_id and producing gnt0, gnt1. The FSM, counters and rvalid pipeline stay in ram_arbiter.
- The bench instantiates ram_arbiter together with the existing BRAM model.

Test Plan:
- Single client: req0 writes addr 5 = 0x1234, then reads addr 5 -> gnt0=1 both cycles; rvalid0=1 one cycle after the read with rdata=0x1234; rvalid1 stays 0.
- Tie fairness: req0 and req1 both held high for reads from reset for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalidN pulses exactly one cycle after its grant.
- Lock bound: LOCK_MAX=4, lock0 and req0 held high, req1 high -> gnt0 for 4 consecutive cycles, then gnt1; lock_cnt returns to 0 in IDLE.
- Lock release: req0 with lock0 granted, req0 dropped next cycle while req1=1 -> gnt1=1 in that same cycle; FSM returns to IDLE.
- Read-modify-write atomicity: client 0 locks, reads addr 3 (=7), writes 8, while client 1 continuously writes addr 3 = 0 -> client 1 is not granted between client 0's read and write; final value is 0 only if client 1's write is granted after the release.
- Reset mid-read: read granted at cycle t, rst=1 at t+1 -> rvalid0=0 at t+1 and t+2; after rst falls, the first tie goes to requester 0.
